// File: rtl/hbridge_gate_sequencer.sv
// hbridge_gate_sequencer
//   Output stage between the hybrid control laws and the H-bridge gate pins.
//   Sequences start-up (bootstrap pre-charge, forced sigma=1, run), inserts a
//   per-device turn-on dead time, and latches a fault on shoot-through commands.
//   Device map: leg 1 = Q[0] high / Q[2] low, leg 2 = Q[1] high / Q[3] low.
// Ports:
//   i_clock        system clock
//   i_RESET        asynchronous active-low reset
//   i_enable       converter enable (registered before use)
//   i_MOSFET[3:0]  gate command from the selected control law
//   i_fault_clear  fault acknowledge, honoured only while enable is low
//   o_Q[3:0]       registered gate drives
//   o_state[2:0]   FSM state (IDLE=0, BOOT=1, FORCE=2, RUN=3, FAULT=4)
//   o_on           high in RUN (decoded from the state register)
//   o_fault        high in FAULT (decoded from the state register)
module hbridge_gate_sequencer #(
    parameter int unsigned DEADTIME     = 20,
    parameter int unsigned BOOT_CYCLES  = 1000,
    parameter int unsigned FORCE_CYCLES = 1000
) (
    input  logic       i_clock,
    input  logic       i_RESET,
    input  logic       i_enable,
    input  logic [3:0] i_MOSFET,
    input  logic       i_fault_clear,
    output logic [3:0] o_Q,
    output logic [2:0] o_state,
    output logic       o_on,
    output logic       o_fault
);

    localparam int unsigned SCNT_W = 16;
    localparam int unsigned DCNT_W = 8;
    localparam int unsigned NDEV   = 4;

    localparam logic [SCNT_W-1:0] BOOT_LAST  = SCNT_W'(BOOT_CYCLES - 1);
    localparam logic [SCNT_W-1:0] FORCE_LAST = SCNT_W'(FORCE_CYCLES - 1);
    localparam logic [SCNT_W-1:0] DT_S       = SCNT_W'(DEADTIME);
    localparam logic [DCNT_W-1:0] DT_D       = DCNT_W'(DEADTIME);
    localparam logic [SCNT_W-1:0] SCNT_MAX   = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BOOT  = 3'd1,
        ST_FORCE = 3'd2,
        ST_RUN   = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t              state, state_next;
    logic [SCNT_W-1:0]   scnt, scnt_next;
    logic [DCNT_W-1:0]   dcnt      [NDEV];
    logic [DCNT_W-1:0]   dcnt_next [NDEV];
    logic [3:0]          cmd_r;
    logic                en_r;
    logic [3:0]          q_r;
    logic [3:0]          q_pre, q_next;
    logic [3:0]          run_drv;
    logic                st;

    assign st = (cmd_r[0] & cmd_r[2]) | (cmd_r[1] & cmd_r[3]);

    // State, counters, input capture and gate drive registers
    always_ff @(posedge i_clock or negedge i_RESET) begin
        if (!i_RESET) begin
            state <= ST_IDLE;
            scnt  <= '0;
            cmd_r <= '0;
            en_r  <= 1'b0;
            q_r   <= '0;
            for (int n = 0; n < int'(NDEV); n++) begin
                dcnt[n] <= '0;
            end
        end else begin
            state <= state_next;
            scnt  <= scnt_next;
            cmd_r <= i_MOSFET;
            en_r  <= i_enable;
            q_r   <= q_next;
            for (int n = 0; n < int'(NDEV); n++) begin
                dcnt[n] <= dcnt_next[n];
            end
        end
    end

    // Next state, counters and next gate drive
    always_comb begin
        state_next = state;
        scnt_next  = '0;
        q_pre      = '0;
        q_next     = '0;
        run_drv    = '0;
        for (int n = 0; n < int'(NDEV); n++) begin
            dcnt_next[n] = '0;
        end

        // Fault entry outranks enable drop, which outranks timer expiry
        case (state)
            ST_IDLE:  if (en_r) state_next = ST_BOOT;
            ST_BOOT: begin
                if (!en_r)                  state_next = ST_IDLE;
                else if (scnt == BOOT_LAST) state_next = ST_FORCE;
            end
            ST_FORCE: begin
                if (!en_r)                   state_next = ST_IDLE;
                else if (scnt == FORCE_LAST) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (st)         state_next = ST_FAULT;
                else if (!en_r) state_next = ST_IDLE;
            end
            ST_FAULT: if (i_fault_clear && !en_r) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        if (state_next != state)   scnt_next = '0;
        else if (scnt == SCNT_MAX) scnt_next = scnt;
        else                       scnt_next = scnt + SCNT_W'(1);

        // Dead-time counters run only in RUN; elsewhere they hold the preload
        // that lets the forced 1001 pattern carry straight into RUN.
        for (int n = 0; n < int'(NDEV); n++) begin
            run_drv[n] = cmd_r[n] & (dcnt[n] == DT_D);
            if (state == ST_RUN) begin
                if (!cmd_r[n])          dcnt_next[n] = '0;
                else if (dcnt[n] == DT_D) dcnt_next[n] = dcnt[n];
                else                    dcnt_next[n] = dcnt[n] + DCNT_W'(1);
            end else begin
                dcnt_next[n] = (n == 0 || n == 3) ? DT_D : '0;
            end
        end

        // Drive pattern for the state being entered, so o_Q tracks o_state
        case (state_next)
            ST_BOOT:  q_pre = 4'b1100;
            ST_FORCE: q_pre = {1'b1, 1'b0, 1'b0, (scnt_next >= DT_S)};
            ST_RUN:   q_pre = run_drv;
            default:  q_pre = 4'b0000;
        endcase

        // Never allow both devices of a leg on together
        q_next = q_pre;
        if (q_pre[0] & q_pre[2]) begin
            q_next[0] = 1'b0;
            q_next[2] = 1'b0;
        end
        if (q_pre[1] & q_pre[3]) begin
            q_next[1] = 1'b0;
            q_next[3] = 1'b0;
        end
    end

    assign o_Q     = q_r;
    assign o_state = state;
    assign o_on    = (state == ST_RUN);
    assign o_fault = (state == ST_FAULT);

endmodule
